// File: rtl/vcmd_v3.sv
// vcmd_v3 -- video command receiver and VRAM write-address generator.
//
// Decodes a byte stream into framebuffer writes. With DataModeEnable=0 a byte
// is a command id or command parameter; with DataModeEnable=1 it is a pixel
// that is written at NextAddr, after which NextAddr advances by Stride.
// A hardware fill writes one value cnt times at stride-spaced addresses.
//
// Handshake: a byte is consumed on every rising edge where ByteValidIn=1.
// There is no backpressure; while BusyOut=1 any valid byte is dropped and
// ErrorOut[1] is set. Each write appears on WriteEnOut/AddrOut/DataOut for
// exactly one cycle, one clock after the byte (or fill step) that caused it.
//
// Ports:
//   ByteClkIn      system clock, rising edge
//   ResetIn        synchronous active-high reset
//   ByteValidIn    ByteIn valid this cycle
//   DataModeEnable 0 = command byte, 1 = data byte
//   ByteIn         incoming byte
//   WriteEnOut     one-cycle VRAM write strobe
//   AddrOut        write address, valid with WriteEnOut
//   DataOut        write data, valid with WriteEnOut
//   BusyOut        fill in progress (high exactly while in the Fill state)
//   ErrorOut       sticky: [0] unknown command, [1] byte dropped while busy

module vcmd_v3 #(
  parameter int AWIDTH = 18,
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              ByteClkIn,
  input  logic              ResetIn,
  input  logic              ByteValidIn,
  input  logic              DataModeEnable,
  input  logic [DWIDTH-1:0] ByteIn,
  output logic              WriteEnOut,
  output logic [AWIDTH-1:0] AddrOut,
  output logic [DWIDTH-1:0] DataOut,
  output logic              BusyOut,
  output logic [1:0]        ErrorOut
);

  localparam int PW = AWIDTH - 16;  // page bits taken from the page byte

  typedef enum logic [3:0] {
    ReadCmdId,
    AddrPage,
    AddrHigh,
    AddrLow,
    StrideByte,
    CntHigh,
    CntLow,
    FillVal,
    Fill
  } state_t;

  state_t            state, stateNext;
  logic [AWIDTH-1:0] nextAddr, nextAddrNext;
  logic [AWIDTH-1:0] stride, strideNext;
  logic [PW-1:0]     pageReg, pageNext;
  logic [7:0]        highReg, highNext;
  logic [CWIDTH-1:0] fillCnt, fillCntNext;
  logic [DWIDTH-1:0] fillVal, fillValNext;
  logic              weNext, busyNext;
  logic [AWIDTH-1:0] addrOutNext;
  logic [DWIDTH-1:0] dataOutNext;
  logic [1:0]        errNext;

  always_ff @(posedge ByteClkIn) begin
    if (ResetIn) begin
      state      <= ReadCmdId;
      nextAddr   <= '0;
      stride     <= AWIDTH'(1);
      pageReg    <= '0;
      highReg    <= '0;
      fillCnt    <= '0;
      fillVal    <= '0;
      WriteEnOut <= 1'b0;
      AddrOut    <= '0;
      DataOut    <= '0;
      BusyOut    <= 1'b0;
      ErrorOut   <= 2'b00;
    end else begin
      state      <= stateNext;
      nextAddr   <= nextAddrNext;
      stride     <= strideNext;
      pageReg    <= pageNext;
      highReg    <= highNext;
      fillCnt    <= fillCntNext;
      fillVal    <= fillValNext;
      WriteEnOut <= weNext;
      AddrOut    <= addrOutNext;
      DataOut    <= dataOutNext;
      BusyOut    <= busyNext;
      ErrorOut   <= errNext;
    end
  end

  always_comb begin
    stateNext    = state;
    nextAddrNext = nextAddr;
    strideNext   = stride;
    pageNext     = pageReg;
    highNext     = highReg;
    fillCntNext  = fillCnt;
    fillValNext  = fillVal;
    weNext       = 1'b0;
    addrOutNext  = AddrOut;
    dataOutNext  = DataOut;
    errNext      = ErrorOut;

    if (state == Fill) begin
      // The write shown this cycle was decided at the previous edge; fillCnt
      // holds the writes still to issue after it.
      if (ByteValidIn) errNext[1] = 1'b1;
      if (fillCnt != '0) begin
        weNext       = 1'b1;
        addrOutNext  = nextAddr;
        dataOutNext  = fillVal;
        nextAddrNext = nextAddr + stride;
        fillCntNext  = fillCnt - 1'b1;
      end else begin
        stateNext = ReadCmdId;
      end
    end else if (ByteValidIn) begin
      if (DataModeEnable) begin
        // Data byte: write it and abandon any partial command.
        weNext       = 1'b1;
        addrOutNext  = nextAddr;
        dataOutNext  = ByteIn;
        nextAddrNext = nextAddr + stride;
        stateNext    = ReadCmdId;
      end else begin
        case (state)
          ReadCmdId: begin
            case (ByteIn)
              8'h00:   stateNext = ReadCmdId;
              8'h01:   stateNext = AddrPage;
              8'h02:   stateNext = StrideByte;
              8'h03:   stateNext = CntHigh;
              default: errNext[0] = 1'b1;
            endcase
          end
          AddrPage: begin
            pageNext  = ByteIn[PW-1:0];
            stateNext = AddrHigh;
          end
          AddrHigh: begin
            highNext  = ByteIn;
            stateNext = AddrLow;
          end
          AddrLow: begin
            nextAddrNext = {pageReg, highReg, ByteIn};
            stateNext    = ReadCmdId;
          end
          StrideByte: begin
            strideNext = AWIDTH'(ByteIn);
            stateNext  = ReadCmdId;
          end
          CntHigh: begin
            fillCntNext[15:8] = ByteIn;
            stateNext         = CntLow;
          end
          CntLow: begin
            fillCntNext[7:0] = ByteIn;
            stateNext        = FillVal;
          end
          FillVal: begin
            fillValNext = ByteIn;
            if (fillCnt != '0) begin
              // First fill write issues together with entering Fill.
              weNext       = 1'b1;
              addrOutNext  = nextAddr;
              dataOutNext  = ByteIn;
              nextAddrNext = nextAddr + stride;
              fillCntNext  = fillCnt - 1'b1;
              stateNext    = Fill;
            end else begin
              stateNext = ReadCmdId;
            end
          end
          default: stateNext = ReadCmdId;
        endcase
      end
    end

    busyNext = (stateNext == Fill);
  end

endmodule

// File: tb/tb_vcmd_v3.sv
// Directed bench for vcmd_v3 (AWIDTH=18). Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, so a write caused by
// the byte taken at an edge is visible right after that edge.

module tb_vcmd_v3;

  logic        ByteClkIn = 1'b0;
  logic        ResetIn;
  logic        ByteValidIn;
  logic        DataModeEnable;
  logic [7:0]  ByteIn;
  logic        WriteEnOut;
  logic [17:0] AddrOut;
  logic [7:0]  DataOut;
  logic        BusyOut;
  logic [1:0]  ErrorOut;

  int n_checks = 0;
  int n_pass   = 0;

  vcmd_v3 dut (
    .ByteClkIn      (ByteClkIn),
    .ResetIn        (ResetIn),
    .ByteValidIn    (ByteValidIn),
    .DataModeEnable (DataModeEnable),
    .ByteIn         (ByteIn),
    .WriteEnOut     (WriteEnOut),
    .AddrOut        (AddrOut),
    .DataOut        (DataOut),
    .BusyOut        (BusyOut),
    .ErrorOut       (ErrorOut)
  );

  // clock / reset
  always #5 ByteClkIn = ~ByteClkIn;

  task automatic do_reset();
    ResetIn = 1'b1;
    ByteValidIn = 1'b0;
    @(posedge ByteClkIn); #1;
    @(posedge ByteClkIn); #1;
    ResetIn = 1'b0;
  endtask

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // drivers
  task automatic send(input logic dme, input logic [7:0] b);
    DataModeEnable = dme;
    ByteIn = b;
    ByteValidIn = 1'b1;
    @(posedge ByteClkIn); #1;
    ByteValidIn = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b);
    send(1'b0, b);
  endtask

  task automatic idle();
    @(posedge ByteClkIn); #1;
  endtask

  // data byte plus check of the write it produces one clock later
  task automatic data_wr(input string tag, input logic [7:0] b, input logic [17:0] exp_addr);
    send(1'b1, b);
    chk({tag, "_we"}, 32'(WriteEnOut), 32'd1);
    chk({tag, "_addr"}, 32'(AddrOut), 32'(exp_addr));
    chk({tag, "_data"}, 32'(DataOut), 32'(b));
  endtask

  initial begin
    ResetIn = 1'b1;
    ByteValidIn = 1'b0;
    DataModeEnable = 1'b0;
    ByteIn = 8'h00;
    do_reset();
    chk("rst_we", 32'(WriteEnOut), 32'd0);
    chk("rst_addr", 32'(AddrOut), 32'd0);
    chk("rst_busy", 32'(BusyOut), 32'd0);
    chk("rst_err", 32'(ErrorOut), 32'd0);

    // basic data writes with default stride 1
    data_wr("d_aa", 8'hAA, 18'h00000);
    data_wr("d_bb", 8'hBB, 18'h00001);
    idle();
    chk("idle_we", 32'(WriteEnOut), 32'd0);

    // SetAddr to top of space, wrap
    cmd(8'h01); cmd(8'h03); cmd(8'hFF);
    chk("cmd_we0", 32'(WriteEnOut), 32'd0);
    cmd(8'hFF);
    chk("cmd_we1", 32'(WriteEnOut), 32'd0);
    data_wr("wrap_11", 8'h11, 18'h3FFFF);
    data_wr("wrap_22", 8'h22, 18'h00000);

    // stride 5, then stride 0
    cmd(8'h01); cmd(8'h00); cmd(8'h01); cmd(8'h00);
    cmd(8'h02); cmd(8'h05);
    data_wr("s5_a", 8'h01, 18'h00100);
    data_wr("s5_b", 8'h02, 18'h00105);
    data_wr("s5_c", 8'h03, 18'h0010A);
    cmd(8'h02); cmd(8'h00);
    data_wr("s0_a", 8'h04, 18'h0010F);
    data_wr("s0_b", 8'h05, 18'h0010F);

    // fill of 4 with stride 1, one byte dropped mid-fill
    cmd(8'h02); cmd(8'h01);
    cmd(8'h03); cmd(8'h00); cmd(8'h04);
    chk("pre_fill_busy", 32'(BusyOut), 32'd0);
    cmd(8'h55);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill%0d_busy", i), 32'(BusyOut), 32'd1);
      chk($sformatf("fill%0d_we", i), 32'(WriteEnOut), 32'd1);
      chk($sformatf("fill%0d_addr", i), 32'(AddrOut), 32'h10F + 32'(i));
      chk($sformatf("fill%0d_data", i), 32'(DataOut), 32'h55);
      if (i == 1) send(1'b1, 8'h99);
      else idle();
    end
    chk("fill_end_busy", 32'(BusyOut), 32'd0);
    chk("fill_end_we", 32'(WriteEnOut), 32'd0);
    chk("drop_err", 32'(ErrorOut), 32'b10);
    data_wr("after_fill", 8'h33, 18'h00113);

    // zero-count fill
    cmd(8'h03); cmd(8'h00); cmd(8'h00); cmd(8'h77);
    chk("fill0_busy", 32'(BusyOut), 32'd0);
    chk("fill0_we", 32'(WriteEnOut), 32'd0);
    idle();
    chk("fill0_busy2", 32'(BusyOut), 32'd0);
    chk("fill0_we2", 32'(WriteEnOut), 32'd0);
    data_wr("after_fill0", 8'h44, 18'h00114);

    // unknown command
    cmd(8'h7E);
    chk("unk_err", 32'(ErrorOut), 32'b11);
    chk("unk_we", 32'(WriteEnOut), 32'd0);
    cmd(8'h01); cmd(8'h00); cmd(8'h00); cmd(8'h10);
    data_wr("unk_then", 8'h5A, 18'h00010);

    // data byte aborts partial SetAddr; next byte is a command again
    cmd(8'h01); cmd(8'h02);
    data_wr("abort", 8'h66, 18'h00011);
    cmd(8'h02); cmd(8'h03);
    data_wr("abort_s3a", 8'h67, 18'h00012);
    data_wr("abort_s3b", 8'h68, 18'h00015);

    // reset in the middle of SetAddr
    cmd(8'h01); cmd(8'h02);
    do_reset();
    chk("rst2_err", 32'(ErrorOut), 32'd0);
    chk("rst2_we", 32'(WriteEnOut), 32'd0);
    data_wr("rst2_a", 8'h77, 18'h00000);
    data_wr("rst2_b", 8'h78, 18'h00001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
